// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the CPU debug/readout logic.
//                Holds the register file geometry, the dump engine state
//                encoding and the layout of one streamed register beat.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } rdr_state_t;

    // One streamed register: value, its index, and end-of-range marker.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] idx;
        logic                  last;
    } beat_t;

    localparam int BEAT_WIDTH = $bits(beat_t);

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word-fall-through output.
//                A write while full is accepted only together with a read.
//  Ports       : clk, rst (sync, active-high)
//                wr_en/wr_data  - push side
//                rd_en/rd_data  - pop side, rd_data shows the head entry
//                full/empty/count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        do_rd = rd_en && !empty;
        // When full, the slot being written is the one being read this cycle.
        do_wr = wr_en && (!full || do_rd);

        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_reader
//  Description : Walks register indices first..last through the register
//                file read port, absorbs the registered read latency and
//                streams each value out on a valid/ready interface.
//  Ports       : clk, rst (sync, active-high)
//                start/first/last   - dump command (sampled in IDLE only)
//                busy/done          - status, done is a one-cycle pulse
//                rf_addr/rf_data    - register file read port
//                out_valid/out_ready/out_data/out_idx/out_last - beat stream
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_reader
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first,
    input  logic [ADDR_WIDTH-1:0] last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last
);

    localparam int BEAT_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
    localparam int IFL_W  = $clog2(READ_LATENCY+1);
    localparam int SUM_W  = $clog2(FIFO_DEPTH+READ_LATENCY+2);

    rdr_state_t            state_q, state_d;
    // One extra bit so that last = all-ones terminates instead of wrapping.
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_WIDTH-1:0] pipe_idx_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_idx_d [READ_LATENCY];

    logic                  issue;
    logic [IFL_W-1:0]      inflight;
    logic [SUM_W-1:0]      credit_used;
    logic [SUM_W-1:0]      credit_limit;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic                  pop;

    logic [BEAT_W-1:0]     fifo_wdata;
    logic [BEAT_W-1:0]     fifo_rdata;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic [CNT_W-1:0]      fifo_count;

    // Tag leaving the pipe lines up with the data the register file returns.
    assign capture    = pipe_vld_q[READ_LATENCY-1];
    assign cap_idx    = pipe_idx_q[READ_LATENCY-1];
    assign fifo_wdata = {rf_data, cap_idx, (cap_idx == last_q)};

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_rdata[BEAT_W-1 -: DATA_WIDTH];
    assign out_idx    = fifo_rdata[ADDR_WIDTH:1];
    assign out_last   = fifo_rdata[0];
    assign pop        = out_valid && out_ready;

    assign busy       = (state_q == RUN);
    assign done       = (state_q == FINISH);
    assign rf_addr    = rf_addr_d;

    sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full_unused),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        rf_addr_d = rf_addr_q;
        issue     = 1'b0;

        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + IFL_W'(pipe_vld_q[i]);
        end
        // A beat leaving this cycle frees its slot in time for a new read,
        // which keeps the stream at one beat per cycle when never stalled.
        credit_used  = SUM_W'(fifo_count) + SUM_W'(inflight);
        credit_limit = SUM_W'(FIFO_DEPTH) + SUM_W'(pop);

        case (state_q)
            IDLE: begin
                if (start) begin
                    last_d  = last;
                    ptr_d   = {1'b0, first};
                    state_d = (first <= last) ? RUN : FINISH;
                end
            end
            RUN: begin
                if ((ptr_q <= {1'b0, last_q}) && (credit_used < credit_limit)) begin
                    issue     = 1'b1;
                    rf_addr_d = ptr_q[ADDR_WIDTH-1:0];
                    ptr_d     = ptr_q + (ADDR_WIDTH+1)'(1);
                end
                if (pop && out_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pipe_vld_d    = '0;
        pipe_vld_d[0] = issue;
        pipe_idx_d[0] = ptr_q[ADDR_WIDTH-1:0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            last_q     <= '0;
            rf_addr_q  <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_idx_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            rf_addr_q  <= rf_addr_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_idx_q <= pipe_idx_d;
        end
    end

endmodule
`default_nettype wire
